// File: rtl/rv32i_clint_pkg.sv
// rtl/rv32i_clint_pkg.sv - shared cause codes, mip bit positions and reset defaults for the CLINT
package rv32i_clint_pkg;

    // mcause interrupt codes handled by this block
    typedef enum logic [3:0] {
        CAUSE_NONE = 4'd0,
        CAUSE_MSI  = 4'd3,
        CAUSE_MTI  = 4'd7,
        CAUSE_MEI  = 4'd11
    } irq_cause_e;

    // bit positions inside o_mip = {MEIP, MTIP, MSIP}
    localparam int MIP_MSIP = 0;
    localparam int MIP_MTIP = 1;
    localparam int MIP_MEIP = 2;

    localparam logic [63:0] MTIMECMP_RESET_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    // fixed priority: external > software > timer
    function automatic logic [3:0] irq_code(input logic [2:0] mip);
        logic [3:0] code;
        code = CAUSE_NONE;
        if (mip[MIP_MEIP]) begin
            code = CAUSE_MEI;
        end else if (mip[MIP_MSIP]) begin
            code = CAUSE_MSI;
        end else if (mip[MIP_MTIP]) begin
            code = CAUSE_MTI;
        end
        return code;
    endfunction

endpackage

// File: rtl/rv32i_clint_if.sv
// rtl/rv32i_clint_if.sv - core-side request/timer/acknowledge bundle of the CLINT
// master: core/bench side (drives i_*), slave: CLINT side (drives o_*).
interface rv32i_clint_if;

    logic        i_external_interrupt;
    logic        i_software_interrupt;
    logic        i_mtime_wr;
    logic        i_mtimecmp_wr;
    logic [63:0] i_mtime_din;
    logic [63:0] i_mtimecmp_din;
    logic        i_ack;
    logic [3:0]  i_ack_code;
    logic [63:0] o_mtime;
    logic [63:0] o_mtimecmp;
    logic [2:0]  o_mip;
    logic        o_irq;
    logic [3:0]  o_irq_code;

    modport master (
        output i_external_interrupt, i_software_interrupt,
        output i_mtime_wr, i_mtimecmp_wr, i_mtime_din, i_mtimecmp_din,
        output i_ack, i_ack_code,
        input  o_mtime, o_mtimecmp, o_mip, o_irq, o_irq_code
    );

    modport slave (
        input  i_external_interrupt, i_software_interrupt,
        input  i_mtime_wr, i_mtimecmp_wr, i_mtime_din, i_mtimecmp_din,
        input  i_ack, i_ack_code,
        output o_mtime, o_mtimecmp, o_mip, o_irq, o_irq_code
    );

endinterface

// File: rtl/rv32i_clint_edge_sync.sv
// rtl/rv32i_clint_edge_sync.sv - optional 2-flop sync, rising-edge detect and sticky pending bit
// Ports: i_clk, i_rst_n (async active-low), i_req (request level),
//        i_clr (acknowledge clear), o_pending (pending bit).
module rv32i_clint_edge_sync #(
    parameter bit SYNC = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req,
    input  logic i_clr,
    output logic o_pending
);

    // Edges are masked until the history flop holds a value sampled after
    // reset, so a request held high through reset release never counts as
    // an edge. With the synchronizer that takes three edges, without it one.
    localparam logic [1:0] PRIME_EDGES = SYNC ? 2'd3 : 2'd1;

    logic       mon;
    logic       hist_q, hist_d;
    logic [1:0] prime_q, prime_d;
    logic       pending_q, pending_d;
    logic       primed;
    logic       rise;

    if (SYNC) begin : g_sync
        logic sync1_q, sync1_d;
        logic sync2_q, sync2_d;

        always_comb begin
            sync1_d = i_req;
            sync2_d = sync1_q;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
            end
        end

        assign mon = sync2_q;
    end else begin : g_nosync
        assign mon = i_req;
    end

    always_comb begin
        primed    = (prime_q == PRIME_EDGES);
        prime_d   = primed ? prime_q : prime_q + 2'd1;
        hist_d    = mon;
        rise      = primed && mon && !hist_q;
        // a new edge in the same cycle as the clear keeps the bit set
        pending_d = rise | (pending_q & ~i_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q    <= 1'b0;
            prime_q   <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            prime_q   <= prime_d;
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;

endmodule

// File: rtl/rv32i_clint.sv
// rtl/rv32i_clint.sv - machine timer (mtime/mtimecmp) and MEIP/MSIP/MTIP pending logic
// Ports: i_clk, i_rst_n (async active-low), bus (rv32i_clint_if.slave:
//        interrupt requests, mtime/mtimecmp loads, trap acknowledge,
//        mtime/mtimecmp/mip/irq/irq_code outputs).
module rv32i_clint
    import rv32i_clint_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ   = 100,
    parameter logic [63:0] MTIMECMP_RESET = MTIMECMP_RESET_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    rv32i_clint_if.slave  bus
);

    localparam logic [9:0] PRESC_LAST = 10'(CLK_FREQ_MHZ - 1);

    logic [9:0]  presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        mtip_q, mtip_d;
    logic        tick;
    logic        meip, msip;
    logic        meip_clr, msip_clr;
    logic [2:0]  mip;

    always_comb begin
        tick = (presc_q == PRESC_LAST);

        presc_d = tick ? 10'd0 : presc_q + 10'd1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        // a load restarts the microsecond and overrides any increment
        if (bus.i_mtime_wr) begin
            presc_d = 10'd0;
            mtime_d = bus.i_mtime_din;
        end

        mtimecmp_d = bus.i_mtimecmp_wr ? bus.i_mtimecmp_din : mtimecmp_q;

        // compare registered values only; level, not cleared by acknowledge
        mtip_d = (mtime_q >= mtimecmp_q);

        meip_clr = bus.i_ack && (bus.i_ack_code == CAUSE_MEI);
        msip_clr = bus.i_ack && (bus.i_ack_code == CAUSE_MSI);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q    <= 10'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RESET;
            mtip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
        end
    end

    rv32i_clint_edge_sync #(.SYNC(1'b1)) u_meip (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (bus.i_external_interrupt),
        .i_clr     (meip_clr),
        .o_pending (meip)
    );

    // software request is already in the i_clk domain
    rv32i_clint_edge_sync #(.SYNC(1'b0)) u_msip (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (bus.i_software_interrupt),
        .i_clr     (msip_clr),
        .o_pending (msip)
    );

    always_comb begin
        mip           = 3'b000;
        mip[MIP_MEIP] = meip;
        mip[MIP_MTIP] = mtip_q;
        mip[MIP_MSIP] = msip;
    end

    assign bus.o_mtime    = mtime_q;
    assign bus.o_mtimecmp = mtimecmp_q;
    assign bus.o_mip      = mip;
    assign bus.o_irq      = |mip;
    assign bus.o_irq_code = irq_code(mip);

endmodule

// File: tb/tb_rv32i_clint.sv
// tb/tb_rv32i_clint.sv - directed table-driven bench for rv32i_clint
module tb_rv32i_clint;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    int   w;

    rv32i_clint_if bus_if ();

    rv32i_clint #(
        .CLK_FREQ_MHZ   (100),
        .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ext;
        logic       sw;
        logic       ack;
        logic [3:0] code;
        logic [2:0] exp_mip;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_to(input int t);
        if (cyc < t) tick(t - cyc);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;

        //                ext   sw    ack   code   mip     code
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  3'b010, 4'd7};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  3'b011, 4'd3};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd0,  3'b111, 4'd11};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'd7,  3'b111, 4'd11};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'd5,  3'b111, 4'd11};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'd11, 3'b011, 4'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  3'b011, 4'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 4'd3,  3'b010, 4'd7};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd7,  3'b010, 4'd7};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  3'b010, 4'd7};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd0,  3'b011, 4'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  3'b011, 4'd3};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'd3,  3'b011, 4'd3};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 4'd3,  3'b010, 4'd7};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 4'd0,  3'b010, 4'd7};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 4'd0,  3'b010, 4'd7};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 4'd11, 3'b110, 4'd11};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 4'd11, 3'b010, 4'd7};

        rst_n                       = 1'b0;
        bus_if.i_external_interrupt = 1'b1;
        bus_if.i_software_interrupt = 1'b1;
        bus_if.i_mtime_wr           = 1'b0;
        bus_if.i_mtimecmp_wr        = 1'b0;
        bus_if.i_mtime_din          = 64'd0;
        bus_if.i_mtimecmp_din       = 64'd0;
        bus_if.i_ack                = 1'b0;
        bus_if.i_ack_code           = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mtime", bus_if.o_mtime, 64'd0);
        chk("rst_mtimecmp", bus_if.o_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mip", 64'(bus_if.o_mip), 64'd0);
        chk("rst_irq", 64'(bus_if.o_irq), 64'd0);
        chk("rst_code", 64'(bus_if.o_irq_code), 64'd0);

        // requests held high through release must not become pending
        rst_n = 1'b1;
        cyc   = 0;
        tick(1);
        chk("held_edge1_mip", 64'(bus_if.o_mip), 64'd0);
        tick(4);
        chk("held_no_set_mip", 64'(bus_if.o_mip), 64'd0);
        chk("mtime_before_tick", bus_if.o_mtime, 64'd0);
        bus_if.i_external_interrupt = 1'b0;
        bus_if.i_software_interrupt = 1'b0;

        // first microsecond, then mtimecmp=15
        run_to(99);
        chk("mtime_at_99", bus_if.o_mtime, 64'd0);
        bus_if.i_mtimecmp_wr  = 1'b1;
        bus_if.i_mtimecmp_din = 64'd15;
        tick(1);
        bus_if.i_mtimecmp_wr = 1'b0;
        chk("mtime_first_tick", bus_if.o_mtime, 64'd1);
        chk("mtimecmp_loaded", bus_if.o_mtimecmp, 64'd15);

        run_to(1499);
        chk("mtime_at_1499", bus_if.o_mtime, 64'd14);
        run_to(1500);
        chk("mtime_at_1500", bus_if.o_mtime, 64'd15);
        chk("mtip_not_yet", 64'(bus_if.o_mip), 64'd0);
        run_to(1501);
        chk("mtip_set_mip", 64'(bus_if.o_mip), 64'b010);
        chk("mtip_set_code", 64'(bus_if.o_irq_code), 64'd7);
        chk("mtip_set_irq", 64'(bus_if.o_irq), 64'd1);

        for (int i = 0; i < 18; i++) begin
            bus_if.i_external_interrupt = vecs[i].ext;
            bus_if.i_software_interrupt = vecs[i].sw;
            bus_if.i_ack                = vecs[i].ack;
            bus_if.i_ack_code           = vecs[i].code;
            tick(1);
            chk($sformatf("vec%0d_mip", i), 64'(bus_if.o_mip), 64'(vecs[i].exp_mip));
            chk($sformatf("vec%0d_code", i), 64'(bus_if.o_irq_code), 64'(vecs[i].exp_code));
            chk($sformatf("vec%0d_irq", i), 64'(bus_if.o_irq), 64'(vecs[i].exp_mip != 3'b000));
        end
        bus_if.i_external_interrupt = 1'b0;
        bus_if.i_software_interrupt = 1'b0;
        bus_if.i_ack                = 1'b0;
        bus_if.i_ack_code           = 4'd0;

        // push mtimecmp out of reach so MTIP drops
        bus_if.i_mtimecmp_wr  = 1'b1;
        bus_if.i_mtimecmp_din = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(1);
        bus_if.i_mtimecmp_wr = 1'b0;
        tick(1);
        chk("mtip_clear_max", 64'(bus_if.o_mip), 64'd0);

        // mtime at all-ones with mtimecmp=0, then wrap to 0
        bus_if.i_mtime_wr     = 1'b1;
        bus_if.i_mtime_din    = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_if.i_mtimecmp_wr  = 1'b1;
        bus_if.i_mtimecmp_din = 64'd0;
        tick(1);
        bus_if.i_mtime_wr    = 1'b0;
        bus_if.i_mtimecmp_wr = 1'b0;
        w = cyc;
        chk("wr_max_mtime", bus_if.o_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr_max_mtimecmp", bus_if.o_mtimecmp, 64'd0);
        chk("wr_max_latency", 64'(bus_if.o_mip), 64'd0);
        tick(1);
        chk("wr_max_mtip", 64'(bus_if.o_mip), 64'b010);
        run_to(w + 99);
        chk("pre_wrap_mtime", bus_if.o_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        run_to(w + 100);
        chk("wrap_mtime", bus_if.o_mtime, 64'd0);
        run_to(w + 101);
        chk("wrap_mtip_holds", 64'(bus_if.o_mip), 64'b010);
        bus_if.i_mtimecmp_wr  = 1'b1;
        bus_if.i_mtimecmp_din = 64'd5;
        tick(1);
        bus_if.i_mtimecmp_wr = 1'b0;
        chk("cmp5_latency", 64'(bus_if.o_mip), 64'b010);
        tick(1);
        chk("cmp5_mtip_clear", 64'(bus_if.o_mip), 64'd0);

        // load coincident with the prescaler wrap
        run_to(w + 199);
        bus_if.i_mtime_wr  = 1'b1;
        bus_if.i_mtime_din = 64'd1000;
        tick(1);
        bus_if.i_mtime_wr = 1'b0;
        chk("load_over_tick", bus_if.o_mtime, 64'd1000);
        run_to(w + 299);
        chk("after_load_99", bus_if.o_mtime, 64'd1000);
        run_to(w + 300);
        chk("after_load_100", bus_if.o_mtime, 64'd1001);

        // asynchronous reset mid-microsecond
        run_to(w + 350);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mtime", bus_if.o_mtime, 64'd0);
        chk("async_rst_mtimecmp", bus_if.o_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("async_rst_mip", 64'(bus_if.o_mip), 64'd0);
        chk("async_rst_code", 64'(bus_if.o_irq_code), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        run_to(99);
        chk("rerst_mtime_99", bus_if.o_mtime, 64'd0);
        run_to(100);
        chk("rerst_mtime_100", bus_if.o_mtime, 64'd1);
        chk("rerst_mip", 64'(bus_if.o_mip), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_clint.md
RV32I_CLINT -- requirements
Module: rv32i_clint

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 100: clock cycles per mtime tick (1 us); legal range 1..1023.
REQ-002 Parameter MTIMECMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF: mtimecmp value after reset.
REQ-003 i_clk  input  1  sole clock, rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous and active-low.
REQ-005 i_external_interrupt  input  1  asynchronous external interrupt request.
REQ-006 i_software_interrupt  input  1  software interrupt request, synchronous to i_clk.
REQ-007 i_mtime_wr  input  1  load mtime from i_mtime_din this cycle.
REQ-008 i_mtimecmp_wr  input  1  load mtimecmp from i_mtimecmp_din this cycle.
REQ-009 i_mtime_din  input  64  mtime load value.
REQ-010 i_mtimecmp_din  input  64  mtimecmp load value.
REQ-011 i_ack  input  1  core is taking an interrupt trap this cycle (go_to_trap qualified by ce_writeback).
REQ-012 i_ack_code  input  4  mcause code of the acknowledged trap (3, 7, 11).
REQ-013 o_mtime  output  64  current mtime.
REQ-014 o_mtimecmp  output  64  current mtimecmp.
REQ-015 o_mip  output  3  pending bits {MEIP, MTIP, MSIP}.
REQ-016 o_irq  output  1  any pending interrupt.
REQ-017 o_irq_code  output  4  highest-priority pending code; 0 when none.

Function
REQ-018 Prescaler counts 0..CLK_FREQ_MHZ-1 and wraps; mtime increments by 1 (mod 2^64) on the wrap cycle.
REQ-019 i_mtime_wr: mtime <= i_mtime_din next edge; prescaler cleared to 0; the load overrides a same-cycle increment.
REQ-020 i_mtimecmp_wr: mtimecmp <= i_mtimecmp_din next edge.
REQ-021 MTIP registered: MTIP <= (mtime >= mtimecmp), unsigned 64-bit, evaluated on registered values; 1-cycle latency after either register changes.
REQ-022 MTIP is level: i_ack with code 7 does not clear it; only a mtimecmp or mtime update making the compare false clears it.
REQ-023 External input passes a 2-flop synchronizer; a rising edge of the synchronized signal sets MEIP; total latency 3 cycles from input change to o_mip[2].
REQ-024 MEIP clears on i_ack with i_ack_code=11; a same-cycle new rising edge wins (MEIP stays 1).
REQ-025 MSIP is set on rising edge of i_software_interrupt (no synchronizer, 1-cycle latency) and cleared on i_ack with code 3; same-cycle set wins.
REQ-026 A held-high request does not re-set its pending bit after acknowledge; a new 0->1 transition is required.
REQ-027 i_ack with any other code is ignored.
REQ-028 o_irq_code priority: 11 (MEIP) > 3 (MSIP) > 7 (MTIP); combinational from pending bits.
REQ-029 o_irq = |o_mip.

Reset
REQ-030 While i_rst_n=0: mtime=0, prescaler=0, mtimecmp=MTIMECMP_RESET, synchronizer and edge-history flops=0, o_mip=0, o_irq=0, o_irq_code=0.
REQ-031 Reset asserted mid-count discards prescaler state; first tick after release occurs CLK_FREQ_MHZ cycles after first active edge.
REQ-032 Requests held high through reset release do not set pending (edge history resets to 0 only if input low; history flops sample input from first active edge, no edge reported on that edge).

Structure
REQ-033 Shared package holds interrupt cause codes (3, 7, 11), MIP bit indices, and MTIMECMP_RESET default.
REQ-034 One sub-module rv32i_clint_edge_sync (optional 2-flop sync + rising-edge detect + set/clear pending flop), instantiated for MEIP and MSIP.

Verification
REQ-035 Reset, write mtimecmp=15 at 1 us, CLK_FREQ_MHZ=100 -> MTIP=1, o_irq_code=7 one cycle after mtime reaches 15 (cycle 1500 after release +1).
REQ-036 Pulse i_external_interrupt high at cycle 10 and hold -> o_mip[2]=1 at cycle 13; i_ack code 11 -> cleared next cycle; stays 0 while input held.
REQ-037 MEIP, MSIP, MTIP all pending -> code 11; ack 11 -> code 3; ack 3 -> code 7; ack 7 -> code stays 7.
REQ-038 mtime_wr 64'hFFFF_FFFF_FFFF_FFFF with mtimecmp=0 -> MTIP=1; after 100 cycles mtime wraps to 0, MTIP stays 1 (0>=0); write mtimecmp=5 -> MTIP=0 next cycle.
REQ-039 i_mtime_wr coincident with prescaler wrap -> mtime equals loaded value, next increment exactly 100 cycles later.
REQ-040 Software rising edge coincident with ack code 3 while MSIP=1 -> MSIP remains 1.
